// File: rtl/dac_x0504_pkg.sv
// -----------------------------------------------------------------------------
// dac_x0504_pkg
// Shared constants and types for the DACx0504 update sequencer.
//   - register addresses of the DAC interface's OPB write port
//   - default TRIGGER data word (LDAC bit)
//   - sequencer state encoding
//   - dac_addr(): channel index -> DACn register address
// Optional feature macro used by files importing this package: DAC_SLEW_LIMIT_EN
// -----------------------------------------------------------------------------
package dac_x0504_pkg;

   localparam int NUM_CH = 4;

   localparam logic [3:0] ADDR_DAC0    = 4'h8;
   localparam logic [3:0] ADDR_DAC1    = 4'h9;
   localparam logic [3:0] ADDR_DAC2    = 4'hA;
   localparam logic [3:0] ADDR_DAC3    = 4'hB;
   localparam logic [3:0] ADDR_TRIGGER = 4'h5;

   localparam logic [15:0] TRIG_WORD_DEFAULT = 16'h0010;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_WRITE = 3'd2,
      ST_GAP   = 3'd3,
      ST_TRIG  = 3'd4,
      ST_TGAP  = 3'd5,
      ST_FIN   = 3'd6
   } seq_state_t;

   // DAC0..DAC3 registers are contiguous, so the address is a plain offset.
   function automatic logic [3:0] dac_addr(input logic [1:0] ch);
      return ADDR_DAC0 + {2'b00, ch};
   endfunction

endpackage

// File: rtl/dac_slew_step.sv
// -----------------------------------------------------------------------------
// dac_slew_step
// Combinational next-code computation for one DAC channel.
// Ports:
//   shadow    in  16  last code written to this channel
//   target    in  16  requested setpoint
//   valid     in  1   shadow holds a code actually written since reset
//   next_code out 16  code to write in the next frame
// Macro DAC_SLEW_LIMIT_EN:
//   defined   - next_code = target clamped to shadow +/- SLEW_STEP (unsigned,
//               never wraps); an invalid shadow jumps straight to target.
//   undefined - next_code = target.
// -----------------------------------------------------------------------------
module dac_slew_step
   import dac_x0504_pkg::*;
#(
   parameter logic [15:0] SLEW_STEP = 16'd64
)
(
   input  logic [15:0] shadow,
   input  logic [15:0] target,
   input  logic        valid,
   output logic [15:0] next_code
);

`ifdef DAC_SLEW_LIMIT_EN
   // Distances are taken in the direction of travel, so shadow +/- SLEW_STEP
   // is only formed when it lies strictly between shadow and target: no wrap.
   always_comb begin
      next_code = target;
      if (valid) begin
         if (target > shadow) begin
            if ((target - shadow) > SLEW_STEP) next_code = shadow + SLEW_STEP;
         end else begin
            if ((shadow - target) > SLEW_STEP) next_code = shadow - SLEW_STEP;
         end
      end
   end
`else
   logic [32:0] unused_slew;
   assign unused_slew = {valid, shadow, SLEW_STEP};
   assign next_code   = target;
`endif

endmodule

// File: rtl/dac_update_sequencer.sv
// -----------------------------------------------------------------------------
// dac_update_sequencer
// Upstream master for the DACx0504 SPI interface. Turns four channel setpoints
// into time-paced OPB register writes (DAC0..DAC3, then TRIGGER) so that all
// DAC outputs update together on the LDAC trigger.
//
// Ports:
//   OPB_CLK    in  1      single clock
//   OPB_RST_N  in  1      asynchronous active-low reset
//   SETPOINT   in  64     {ch3,ch2,ch1,ch0} 16-bit target codes
//   SP_LOAD    in  1      pulse: latch SETPOINT into the target registers
//   CH_MASK    in  4      channel enable; 0 = channel never written
//   START      in  1      pulse: request one update frame
//   PERIOD     in  PER_W  auto-frame interval in cycles; 0 = auto off
//   M_WE       out 1      one-cycle write strobe to the DAC interface
//   M_ADDR     out 4      register address (8..B = DAC0..3, 5 = TRIGGER)
//   M_DI       out 16     write data
//   BUSY       out 1      high from frame accept until the cycle after DONE
//   DONE       out 1      one-cycle pulse at frame end
//   FRAME_CNT  out 16     completed frames, wraps
//   DBG_STATE  out 3      current sequencer state (seq_state_t encoding)
//
// Handshake: the write port is strobe-only. M_ADDR/M_DI are valid exactly in
// the cycle M_WE=1 and hold their last value otherwise; the DAC interface has
// no ready, so flow control is purely temporal: M_WE pulses within a frame are
// exactly GAP_CYCLES apart (start to start), and DONE comes GAP_CYCLES-1
// cycles after the TRIGGER write.
//
// Optional feature macro: DAC_SLEW_LIMIT_EN (per-frame slew limiting with
// automatic re-run until every enabled channel reaches its target).
// -----------------------------------------------------------------------------
module dac_update_sequencer
   import dac_x0504_pkg::*;
#(
   parameter int          GAP_CYCLES = 256,
   parameter logic [15:0] TRIG_WORD  = TRIG_WORD_DEFAULT,
   parameter logic [15:0] SLEW_STEP  = 16'd64,
   parameter int          PER_W      = 24
)
(
   input  logic             OPB_CLK,
   input  logic             OPB_RST_N,
   input  logic [63:0]      SETPOINT,
   input  logic             SP_LOAD,
   input  logic [3:0]       CH_MASK,
   input  logic             START,
   input  logic [PER_W-1:0] PERIOD,
   output logic             M_WE,
   output logic [3:0]       M_ADDR,
   output logic [15:0]      M_DI,
   output logic             BUSY,
   output logic             DONE,
   output logic [15:0]      FRAME_CNT,
   output logic [2:0]       DBG_STATE
);

   localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   // Last value of the gap counter: WRITE/TRIG occupy one cycle and SCAN one
   // more, so the wait itself is GAP_CYCLES-2 cycles long.
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);

   seq_state_t       state;
   logic [15:0]      target     [NUM_CH];
   logic [15:0]      shadow     [NUM_CH];
   logic [NUM_CH-1:0] shadow_vld;
   logic [15:0]      next_code  [NUM_CH];
   logic [NUM_CH-1:0] need_wr;
   logic [2:0]       scan_from;
   logic             wrote;
   logic             pending;
   logic [GAP_W-1:0] gap_cnt;
   logic             gap_done;
   logic [PER_W-1:0] per_cnt;
   logic             per_tick;
   logic             frame_req;
   logic             rerun;
   logic             sel_found;
   logic [1:0]       sel_idx;

   // ---------------------------------------------------------------- targets
   always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
      if (!OPB_RST_N) begin
         for (int i = 0; i < NUM_CH; i++) target[i] <= '0;
      end else if (SP_LOAD) begin
         for (int i = 0; i < NUM_CH; i++) target[i] <= SETPOINT[16*i +: 16];
      end
   end

   // ---------------------------------------------------------- period timer
   // Free-running so that a tick landing mid-frame is remembered as pending.
   assign per_tick = (PERIOD != '0) && (per_cnt >= (PERIOD - 1'b1));

   always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
      if (!OPB_RST_N) begin
         per_cnt <= '0;
      end else if ((PERIOD == '0) || per_tick) begin
         per_cnt <= '0;
      end else begin
         per_cnt <= per_cnt + 1'b1;
      end
   end

   assign frame_req = START || per_tick;

   // ---------------------------------------------------- per-channel next code
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      dac_slew_step #(
         .SLEW_STEP (SLEW_STEP)
      ) u_step (
         .shadow    (shadow[g]),
         .target    (target[g]),
         .valid     (shadow_vld[g]),
         .next_code (next_code[g])
      );
      assign need_wr[g] = CH_MASK[g] && (!shadow_vld[g] || (next_code[g] != shadow[g]));
   end

   // Lowest channel at or above scan_from that still needs a write.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = 2'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (need_wr[i] && (3'(i) >= scan_from)) begin
            sel_found = 1'b1;
            sel_idx   = 2'(i);
         end
      end
   end

`ifdef DAC_SLEW_LIMIT_EN
   // Any enabled channel still short of its target forces another frame.
   always_comb begin
      rerun = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (CH_MASK[i] && (!shadow_vld[i] || (shadow[i] != target[i]))) rerun = 1'b1;
      end
   end
`else
   assign rerun = 1'b0;
`endif

   assign gap_done = (gap_cnt == GAP_LAST);

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
      if (!OPB_RST_N) begin
         state      <= ST_IDLE;
         M_WE       <= 1'b0;
         M_ADDR     <= '0;
         M_DI       <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         FRAME_CNT  <= '0;
         pending    <= 1'b0;
         wrote      <= 1'b0;
         scan_from  <= '0;
         gap_cnt    <= '0;
         shadow_vld <= '0;
         for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      end else begin
         M_WE <= 1'b0;
         DONE <= 1'b0;

         // Single-depth request memory; IDLE and FIN consume requests directly.
         if (frame_req && (state != ST_IDLE) && (state != ST_FIN)) pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (frame_req || pending) begin
                  state     <= ST_SCAN;
                  BUSY      <= 1'b1;
                  pending   <= 1'b0;
                  wrote     <= 1'b0;
                  scan_from <= '0;
               end
            end

            ST_SCAN: begin
               if (sel_found) begin
                  M_WE                <= 1'b1;
                  M_ADDR              <= dac_addr(sel_idx);
                  M_DI                <= next_code[sel_idx];
                  shadow[sel_idx]     <= next_code[sel_idx];
                  shadow_vld[sel_idx] <= 1'b1;
                  scan_from           <= {1'b0, sel_idx} + 3'd1;
                  wrote               <= 1'b1;
                  state               <= ST_WRITE;
               end else if (wrote) begin
                  M_WE   <= 1'b1;
                  M_ADDR <= ADDR_TRIGGER;
                  M_DI   <= TRIG_WORD;
                  state  <= ST_TRIG;
               end else begin
                  // Nothing changed: finish without touching LDAC.
                  DONE      <= 1'b1;
                  FRAME_CNT <= FRAME_CNT + 16'd1;
                  state     <= ST_FIN;
               end
            end

            ST_WRITE: begin
               gap_cnt <= GAP_W'(1);
               state   <= (GAP_CYCLES == 2) ? ST_SCAN : ST_GAP;
            end

            ST_GAP: begin
               if (gap_done) state <= ST_SCAN;
               else          gap_cnt <= gap_cnt + 1'b1;
            end

            ST_TRIG: begin
               gap_cnt <= GAP_W'(1);
               if (GAP_CYCLES == 2) begin
                  DONE      <= 1'b1;
                  FRAME_CNT <= FRAME_CNT + 16'd1;
                  state     <= ST_FIN;
               end else begin
                  state <= ST_TGAP;
               end
            end

            ST_TGAP: begin
               if (gap_done) begin
                  DONE      <= 1'b1;
                  FRAME_CNT <= FRAME_CNT + 16'd1;
                  state     <= ST_FIN;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            ST_FIN: begin
               // Back-to-back frame: BUSY stays high, next SCAN is the next cycle.
               if (frame_req || pending || rerun) begin
                  state     <= ST_SCAN;
                  pending   <= 1'b0;
                  wrote     <= 1'b0;
                  scan_from <= '0;
               end else begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign DBG_STATE = state;

endmodule
